// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the in-place radix-2 DIT FFT sequencer:
// controller state encoding, default sizing and the stage-counter width helper.
package fft_stage_ctrl_pkg;

    localparam int unsigned DEF_LOG2N      = 4;
    localparam int unsigned DEF_BF_LATENCY = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } ctrl_state_t;

    function automatic int unsigned stage_width(input int unsigned log2n);
        return (log2n > 2) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address map: (stage, butterfly) -> operand addresses A, B
// and twiddle index k for an in-place radix-2 DIT FFT.
module fft_addr_gen
    import fft_stage_ctrl_pkg::*;
#(
    parameter  int unsigned LOG2N = DEF_LOG2N,
    localparam int unsigned SW    = stage_width(LOG2N)
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] bf_idx,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr
);

    localparam logic [SW-1:0] TOP_STAGE = SW'(LOG2N - 1);

    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [SW-1:0]    tw_shift;

    always_comb begin
        b_ext    = {1'b0, bf_idx};
        half     = {{(LOG2N-1){1'b0}}, 1'b1} << stage;
        pos      = b_ext & (half - 1'b1);
        grp      = b_ext >> stage;
        // Shift in two steps so stage+1 never has to fit in the stage width.
        addr_a   = ((grp << stage) << 1) | pos;
        addr_b   = addr_a + half;
        tw_shift = TOP_STAGE - stage;
        tw_addr  = pos[LOG2N-2:0] << tw_shift;
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Sequencer for a single radix-2 butterfly unit: walks every butterfly of every
// stage, one in flight at a time, driving RAM/ROM addresses and strobes.
module fft_stage_ctrl
    import fft_stage_ctrl_pkg::*;
#(
    parameter  int unsigned LOG2N      = DEF_LOG2N,
    parameter  int unsigned BF_LATENCY = DEF_BF_LATENCY,
    localparam int unsigned SW         = stage_width(LOG2N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_start,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [SW-1:0]    stage,
    output logic [LOG2N-2:0] bf_idx
);

    localparam int unsigned   CW        = $clog2(BF_LATENCY + 1);
    localparam logic [SW-1:0] LAST_STG  = SW'(LOG2N - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(BF_LATENCY);
    localparam logic [CW-1:0] WAIT_LAST = CW'(1);

    ctrl_state_t state, state_next;

    logic [CW-1:0]    wait_cnt;
    logic             load_bf;
    logic [SW-1:0]    stage_next;
    logic [LOG2N-2:0] bf_next;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_k;

    // Addresses are computed for the butterfly about to be issued and
    // captured on entry to READ, so they stay stable for the whole butterfly.
    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .stage   (stage_next),
        .bf_idx  (bf_next),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_bf    = 1'b0;
        stage_next = stage;
        bf_next    = bf_idx;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        bf_start   = 1'b0;
        wr_en      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                    load_bf    = 1'b1;
                    stage_next = '0;
                    bf_next    = '0;
                end
            end
            ST_READ: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                state_next = ST_CALC;
            end
            ST_CALC: begin
                busy       = 1'b1;
                bf_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (bf_idx != '1) begin
                    state_next = ST_READ;
                    load_bf    = 1'b1;
                    bf_next    = bf_idx + 1'b1;
                end else if (stage != LAST_STG) begin
                    state_next = ST_READ;
                    load_bf    = 1'b1;
                    bf_next    = '0;
                    stage_next = stage + 1'b1;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= '0;
            bf_idx    <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            wr_addr_a <= '0;
            wr_addr_b <= '0;
            wait_cnt  <= '0;
        end else begin
            if (load_bf) begin
                stage     <= stage_next;
                bf_idx    <= bf_next;
                rd_addr_a <= gen_a;
                rd_addr_b <= gen_b;
                tw_addr   <= gen_k;
            end
            if (state == ST_CALC) begin
                wait_cnt  <= WAIT_LOAD;
                wr_addr_a <= rd_addr_a;
                wr_addr_b <= rd_addr_b;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomized self-checking bench for fft_stage_ctrl: two configurations checked
// cycle by cycle against an arithmetic schedule/address model.
module tb_fft_stage_ctrl;

    localparam int L0 = 3;
    localparam int B0 = 2;
    localparam int L1 = 4;
    localparam int B1 = 4;

    typedef struct {
        int busy;
        int done;
        int rd_en;
        int bf_start;
        int wr_en;
        int rda;
        int rdb;
        int tw;
        int wra;
        int wrb;
        int stage;
        int bf;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance 0: LOG2N=3, BF_LATENCY=2
    logic          rst0, start0;
    logic          busy0, done0, rd_en0, bf_start0, wr_en0;
    logic [L0-1:0] rda0, rdb0, wra0, wrb0;
    logic [L0-2:0] tw0, bf0;
    logic [1:0]    stage0;

    fft_stage_ctrl #(.LOG2N(L0), .BF_LATENCY(B0)) u0 (
        .clk(clk), .rst_n(rst0), .start(start0), .busy(busy0), .done(done0),
        .rd_en(rd_en0), .rd_addr_a(rda0), .rd_addr_b(rdb0), .tw_addr(tw0),
        .bf_start(bf_start0), .wr_en(wr_en0), .wr_addr_a(wra0), .wr_addr_b(wrb0),
        .stage(stage0), .bf_idx(bf0)
    );

    // ---------------- instance 1: LOG2N=4, BF_LATENCY=4
    logic          rst1, start1;
    logic          busy1, done1, rd_en1, bf_start1, wr_en1;
    logic [L1-1:0] rda1, rdb1, wra1, wrb1;
    logic [L1-2:0] tw1, bf1;
    logic [1:0]    stage1;

    fft_stage_ctrl #(.LOG2N(L1), .BF_LATENCY(B1)) u1 (
        .clk(clk), .rst_n(rst1), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr_a(rda1), .rd_addr_b(rdb1), .tw_addr(tw1),
        .bf_start(bf_start1), .wr_en(wr_en1), .wr_addr_a(wra1), .wr_addr_b(wrb1),
        .stage(stage1), .bf_idx(bf1)
    );

    obs_t o0, o1;

    always_comb begin
        o0.busy = 32'(busy0);   o0.done = 32'(done0);   o0.rd_en = 32'(rd_en0);
        o0.bf_start = 32'(bf_start0); o0.wr_en = 32'(wr_en0);
        o0.rda = 32'(rda0); o0.rdb = 32'(rdb0); o0.tw = 32'(tw0);
        o0.wra = 32'(wra0); o0.wrb = 32'(wrb0);
        o0.stage = 32'(stage0); o0.bf = 32'(bf0);
    end

    always_comb begin
        o1.busy = 32'(busy1);   o1.done = 32'(done1);   o1.rd_en = 32'(rd_en1);
        o1.bf_start = 32'(bf_start1); o1.wr_en = 32'(wr_en1);
        o1.rda = 32'(rda1); o1.rdb = 32'(rdb1); o1.tw = 32'(tw1);
        o1.wra = 32'(wra1); o1.wrb = 32'(wrb1);
        o1.stage = 32'(stage1); o1.bf = 32'(bf1);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t get_obs(input int idx);
        return (idx == 0) ? o0 : o1;
    endfunction

    task automatic set_start(input int idx, input logic v);
        if (idx == 0) start0 = v; else start1 = v;
    endtask

    task automatic set_rst(input int idx, input logic v);
        if (idx == 0) rst0 = v; else rst1 = v;
    endtask

    task automatic check_zero(input int idx, input string pfx);
        obs_t o;
        o = get_obs(idx);
        check_eq({pfx, " busy"},     o.busy,     0);
        check_eq({pfx, " done"},     o.done,     0);
        check_eq({pfx, " rd_en"},    o.rd_en,    0);
        check_eq({pfx, " bf_start"}, o.bf_start, 0);
        check_eq({pfx, " wr_en"},    o.wr_en,    0);
        check_eq({pfx, " rd_addr_a"}, o.rda,     0);
        check_eq({pfx, " rd_addr_b"}, o.rdb,     0);
        check_eq({pfx, " tw_addr"},  o.tw,       0);
        check_eq({pfx, " wr_addr_a"}, o.wra,     0);
        check_eq({pfx, " wr_addr_b"}, o.wrb,     0);
        check_eq({pfx, " stage"},    o.stage,    0);
        check_eq({pfx, " bf_idx"},   o.bf,       0);
    endtask

    // One full transform (or until abort_c, where reset is asserted).
    // Model: cycle c after accept belongs to butterfly n=(c-1)/P in phase (c-1)%P,
    // butterflies are numbered stage-major, addresses follow the DIT group layout.
    task automatic run(input int idx, input bit hold, input int abort_c);
        int lg, bl, h, p, t, n, ph, s, b, half, a, k, wr_seen;
        string pf;
        obs_t o;
        lg = (idx == 0) ? L0 : L1;
        bl = (idx == 0) ? B0 : B1;
        h  = 1 << (lg - 1);
        p  = 3 + bl;
        t  = lg * h * p;
        wr_seen = 0;
        @(negedge clk);
        set_start(idx, 1'b1);
        @(posedge clk);
        for (int c = 1; c <= t + 2; c++) begin
            @(negedge clk);
            o  = get_obs(idx);
            pf = $sformatf("u%0d c%0d", idx, c);
            if (c == t + 2 || c == abort_c) set_start(idx, 1'b0);
            else set_start(idx, hold ? 1'b1 : 1'($urandom_range(0, 1)));
            if (o.wr_en != 0) wr_seen++;
            if (c <= t) begin
                n = (c - 1) / p;  ph = (c - 1) % p;
                s = n / h;        b  = n % h;
                half = 1 << s;
                a = (b / half) * 2 * half + (b % half);
                k = (b % half) * (h / half);
                check_eq({pf, " busy"},     o.busy,     1);
                check_eq({pf, " done"},     o.done,     0);
                check_eq({pf, " rd_en"},    o.rd_en,    int'(ph == 0));
                check_eq({pf, " bf_start"}, o.bf_start, int'(ph == 1));
                check_eq({pf, " wr_en"},    o.wr_en,    int'(ph == p - 1));
                check_eq({pf, " stage"},    o.stage,    s);
                check_eq({pf, " bf_idx"},   o.bf,       b);
                if (ph == 0) begin
                    check_eq({pf, " rd_addr_a"}, o.rda, a);
                    check_eq({pf, " rd_addr_b"}, o.rdb, a + half);
                    check_eq({pf, " tw_addr"},   o.tw,  k);
                end
                if (ph == p - 1) begin
                    check_eq({pf, " wr_addr_a"}, o.wra, a);
                    check_eq({pf, " wr_addr_b"}, o.wrb, a + half);
                end
                if (c == abort_c) begin
                    set_rst(idx, 1'b0);
                    #1;
                    check_zero(idx, {pf, " async-rst"});
                    @(negedge clk);
                    check_zero(idx, {pf, " in-rst"});
                    set_rst(idx, 1'b1);
                    for (int i = 0; i < 4; i++) begin
                        @(negedge clk);
                        o = get_obs(idx);
                        check_eq($sformatf("u%0d post-rst%0d done", idx, i), o.done, 0);
                        check_eq($sformatf("u%0d post-rst%0d busy", idx, i), o.busy, 0);
                        check_eq($sformatf("u%0d post-rst%0d wr_en", idx, i), o.wr_en, 0);
                    end
                    return;
                end
            end else begin
                check_eq({pf, " done"},  o.done,  int'(c == t + 1));
                check_eq({pf, " busy"},  o.busy,  0);
                check_eq({pf, " rd_en"}, o.rd_en, 0);
                check_eq({pf, " bf_start"}, o.bf_start, 0);
                check_eq({pf, " wr_en"}, o.wr_en, 0);
            end
        end
        check_eq($sformatf("u%0d write count", idx), wr_seen, lg * h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int ab;
        rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(0, "u0 reset");
        check_zero(1, "u1 reset");
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 1'b1, 0);
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(0, 1'b0, 0);
        end

        // reset during a random stage-1 butterfly, in a random WAIT cycle
        ab = (4 + int'($urandom_range(0, 3))) * (3 + B0) + 2 + int'($urandom_range(0, B0 - 1)) + 1;
        run(0, 1'b0, ab);
        run(0, 1'b0, 0);

        run(1, 1'b0, 0);
        run(1, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
